// File: rtl/axis_chk_pkg.sv
// Shared types and pattern helpers for the AXI-Stream loopback checker.
// Both the generator and the checker build their words from these functions.
package axis_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam logic [31:0] LFSR_POLY = 32'h80200003;
    localparam logic [31:0] LFSR_SEED = 32'h0000ACE1;
    localparam int          MAX_W     = 512;

    // Right-shifting Galois form: feedback taps applied when bit 0 falls out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) begin
            n = n ^ LFSR_POLY;
        end
        return n;
    endfunction

    function automatic logic [MAX_W-1:0] expand_word(
        input logic [31:0] w,
        input logic        rep
    );
        logic [MAX_W-1:0] r;
        r = '0;
        if (rep) begin
            r = {(MAX_W / 32){w}};
        end else begin
            r[31:0] = w;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_pattern_gen.sv
// Frame/beat counters plus LFSR producing the reference word stream.
// Advances one beat per advance_i; clear_i reseeds everything.
module axis_pattern_gen
    import axis_chk_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_BEATS    = 16,
    parameter int NUM_FRAMES   = 4,
    parameter int PATTERN_MODE = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  advance_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic                  final_o
);

    localparam logic [15:0] LAST_BEAT  = 16'(NUM_BEATS - 1);
    localparam logic [15:0] LAST_FRAME = 16'(NUM_FRAMES - 1);
    localparam logic        USE_LFSR   = (PATTERN_MODE != 0);

    logic [15:0] beat_q, beat_d;
    logic [15:0] frame_q, frame_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [31:0] word;

    assign last_o  = (beat_q == LAST_BEAT);
    assign final_o = last_o && (frame_q == LAST_FRAME);
    assign word    = USE_LFSR ? lfsr_q : {frame_q, beat_q};
    assign data_o  = DATA_WIDTH'(expand_word(word, USE_LFSR));

    always_comb begin
        beat_d  = beat_q;
        frame_d = frame_q;
        lfsr_d  = lfsr_q;
        if (clear_i) begin
            beat_d  = '0;
            frame_d = '0;
            lfsr_d  = LFSR_SEED;
        end else if (advance_i) begin
            lfsr_d = lfsr_next(lfsr_q);
            if (last_o) begin
                beat_d  = '0;
                frame_d = final_o ? 16'd0 : frame_q + 16'd1;
            end else begin
                beat_d = beat_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q  <= '0;
            frame_q <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            beat_q  <= beat_d;
            frame_q <= frame_d;
            lfsr_q  <= lfsr_d;
        end
    end

endmodule

// File: rtl/axis_stream_loopback_checker.sv
// AXI-Stream traffic source and sink closing a loop through an external FIFO.
// Launches NUM_FRAMES x NUM_BEATS beats and checks the returned stream.
module axis_stream_loopback_checker
    import axis_chk_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          NUM_BEATS    = 16,
    parameter int          NUM_FRAMES   = 4,
    parameter int          PATTERN_MODE = 0,
    parameter logic [7:0]  READY_MASK   = 8'hFF,
    parameter int          TIMEOUT      = 1024
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  init_axi_txn,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  compare_done,
    output logic                  error_out,
    output logic [15:0]           err_count
);

    localparam logic TO_EN = (TIMEOUT != 0);

    state_e      state_q;
    logic        init_q, init_prev_q;
    logic        gen_done_q;
    logic [2:0]  phase_q;
    logic [31:0] idle_q;

    logic                  start;
    logic                  in_run;
    logic                  m_hs, s_hs;
    logic                  mismatch, chk_end, timeout_hit;
    logic [DATA_WIDTH-1:0] gen_data, chk_data;
    logic                  gen_last, gen_final;
    logic                  chk_last, chk_final;

    assign in_run = (state_q == RUN);
    assign start  = init_q && !init_prev_q && !in_run;

    assign m_axis_tvalid = in_run && !gen_done_q;
    assign m_axis_tdata  = m_axis_tvalid ? gen_data : '0;
    assign m_axis_tlast  = m_axis_tvalid && gen_last;
    assign s_axis_tready = in_run && READY_MASK[phase_q];

    assign m_hs = m_axis_tvalid && m_axis_tready;
    assign s_hs = s_axis_tvalid && s_axis_tready;

    assign mismatch = s_hs && ((s_axis_tdata != chk_data) ||
                               (s_axis_tlast != chk_last));
    assign chk_end  = s_hs && chk_final;
    // An accept in the same cycle always clears the idle count first.
    assign timeout_hit = TO_EN && !s_hs &&
                         (idle_q + 32'd1 == 32'(TIMEOUT));

    axis_pattern_gen #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_BEATS   (NUM_BEATS),
        .NUM_FRAMES  (NUM_FRAMES),
        .PATTERN_MODE(PATTERN_MODE)
    ) u_gen (
        .clk_i    (aclk),
        .rst_ni   (aresetn),
        .clear_i  (start),
        .advance_i(m_hs),
        .data_o   (gen_data),
        .last_o   (gen_last),
        .final_o  (gen_final)
    );

    axis_pattern_gen #(
        .DATA_WIDTH  (DATA_WIDTH),
        .NUM_BEATS   (NUM_BEATS),
        .NUM_FRAMES  (NUM_FRAMES),
        .PATTERN_MODE(PATTERN_MODE)
    ) u_chk (
        .clk_i    (aclk),
        .rst_ni   (aresetn),
        .clear_i  (start),
        .advance_i(s_hs),
        .data_o   (chk_data),
        .last_o   (chk_last),
        .final_o  (chk_final)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            init_q       <= 1'b0;
            init_prev_q  <= 1'b0;
            gen_done_q   <= 1'b0;
            phase_q      <= '0;
            idle_q       <= '0;
            compare_done <= 1'b0;
            error_out    <= 1'b0;
            err_count    <= '0;
        end else begin
            init_q      <= init_axi_txn;
            init_prev_q <= init_q;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= RUN;
                        gen_done_q   <= 1'b0;
                        phase_q      <= '0;
                        idle_q       <= '0;
                        compare_done <= 1'b0;
                        error_out    <= 1'b0;
                        err_count    <= '0;
                    end
                end
                RUN: begin
                    phase_q <= phase_q + 3'd1;
                    idle_q  <= s_hs ? 32'd0 : idle_q + 32'd1;
                    if (m_hs && gen_final) begin
                        gen_done_q <= 1'b1;
                    end
                    if (mismatch) begin
                        error_out <= 1'b1;
                        if (err_count != 16'hFFFF) begin
                            err_count <= err_count + 16'd1;
                        end
                    end
                    if (chk_end) begin
                        state_q      <= DONE;
                        compare_done <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q      <= DONE;
                        compare_done <= 1'b1;
                        error_out    <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_stream_loopback_checker.sv
// Scoreboard bench: direct loop (A, TIMEOUT=32) and FIFO loop (B, LFSR, 64b).
// Beats are checked against a local pattern model; run results via a queue.
module tb_axis_stream_loopback_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        bit err;
        int cnt;
        int lat;
        int beats;
    } res_t;

    res_t       sb[$];
    logic [32:0] qa[$];
    logic [64:0] qb[$];
    logic [64:0] fifo_b[$];

    // DUT A: direct wire with optional bit flip and loop break
    logic        a_init;
    logic [31:0] a_md, a_sd;
    logic        a_mv, a_ml, a_mr, a_sv, a_sl, a_sr;
    logic        a_done, a_err;
    logic [15:0] a_cnt;
    logic        a_hold = 1'b0;
    logic        a_flip = 1'b0;

    assign a_sd = a_md ^ (a_flip ? 32'h8 : 32'h0);
    assign a_sv = a_mv & ~a_hold;
    assign a_sl = a_ml;
    assign a_mr = a_sr & ~a_hold;

    axis_stream_loopback_checker #(
        .TIMEOUT(32)
    ) u_a (
        .aclk         (clk),
        .aresetn      (rst_n),
        .init_axi_txn (a_init),
        .m_axis_tdata (a_md),
        .m_axis_tvalid(a_mv),
        .m_axis_tlast (a_ml),
        .m_axis_tready(a_mr),
        .s_axis_tdata (a_sd),
        .s_axis_tvalid(a_sv),
        .s_axis_tlast (a_sl),
        .s_axis_tready(a_sr),
        .compare_done (a_done),
        .error_out    (a_err),
        .err_count    (a_cnt)
    );

    // DUT B: LFSR, 64-bit, sparse sink mask, FIFO in the loop
    logic        b_init;
    logic [63:0] b_md, b_sd;
    logic        b_mv, b_ml, b_mr, b_sv, b_sl, b_sr;
    logic        b_done, b_err;
    logic [15:0] b_cnt;

    axis_stream_loopback_checker #(
        .DATA_WIDTH  (64),
        .PATTERN_MODE(1),
        .READY_MASK  (8'b1010_0101)
    ) u_b (
        .aclk         (clk),
        .aresetn      (rst_n),
        .init_axi_txn (b_init),
        .m_axis_tdata (b_md),
        .m_axis_tvalid(b_mv),
        .m_axis_tlast (b_ml),
        .m_axis_tready(b_mr),
        .s_axis_tdata (b_sd),
        .s_axis_tvalid(b_sv),
        .s_axis_tlast (b_sl),
        .s_axis_tready(b_sr),
        .compare_done (b_done),
        .error_out    (b_err),
        .err_count    (b_cnt)
    );

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_lfsr(input logic [31:0] s);
        logic [31:0] n;
        n = {1'b0, s[31:1]};
        if (s[0]) n = n ^ 32'h80200003;
        return n;
    endfunction

    task automatic finish_run(input string tag, input bit done,
                              input bit err, input logic [15:0] cnt,
                              input int lat, input int beats);
        res_t e;
        if (sb.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_err"}, err, e.err);
        check_eq({tag, "_cnt"}, cnt, e.cnt);
        check_eq({tag, "_beats"}, beats, e.beats);
        if (e.lat >= 0) check_eq({tag, "_lat"}, lat, e.lat);
    endtask

    task automatic run_a(input bit flip, input bit brk, input bit hold,
                         input int rst_at);
        int   ka, last;
        bit   pend, seen;
        res_t e;
        ka = 0; last = 0; pend = 0;
        qa.delete();
        for (int f = 0; f < 4; f++)
            for (int b = 0; b < 16; b++)
                qa.push_back({b == 15, f[15:0], b[15:0]});
        if (rst_at < 0) begin
            e.err   = flip || brk;
            e.cnt   = flip ? 1 : 0;
            e.lat   = brk ? 32 : 0;
            e.beats = brk ? 10 : 64;
            sb.push_back(e);
        end
        @(negedge clk) a_init = 1'b1;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = a_mv;
        end
        check_eq("a_start", seen, 1);
        if (!hold) a_init = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (pend) begin
                ka++;
                last = cyc;
            end
            if (a_done) break;
            if (rst_at >= 0 && ka == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("a_rst_outs",
                         {a_mv, a_ml, a_md, a_sr, a_done, a_err, a_cnt}, 0);
                @(negedge clk);
                @(negedge clk) rst_n = 1'b1;
                repeat (3) @(negedge clk);
                check_eq("a_rst_novalid", {a_mv, a_done}, 0);
                qa.delete();
                return;
            end
            if (hold && ka == 20) a_init = 1'b0;
            if (hold && ka == 25) a_init = 1'b1;
            a_hold = brk && ka >= 10;
            a_flip = flip && ka == 37;
            pend = a_mv && a_sr && !a_hold;
            if (pend) begin
                if (qa.size() == 0) check_eq("a_extra_beat", 1, 0);
                else check_eq("a_beat", {a_ml, a_md}, qa.pop_front());
            end
            @(negedge clk);
        end
        a_hold = 1'b0;
        a_flip = 1'b0;
        finish_run("a", a_done, a_err, a_cnt, cyc - last, ka);
        a_init = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("a_held", {a_done, a_mv}, 2'b10);
        qa.delete();
    endtask

    task automatic run_b();
        int          kb;
        bit          pm, ps, seen, first;
        logic [64:0] pm_val;
        logic [31:0] s;
        res_t        e;
        kb = 0; pm = 0; ps = 0; first = 1; pm_val = '0;
        s = 32'h0000ACE1;
        qb.delete();
        fifo_b.delete();
        for (int i = 0; i < 64; i++) begin
            qb.push_back({(i % 16) == 15, s, s});
            s = m_lfsr(s);
        end
        e.err = 0; e.cnt = 0; e.lat = -1; e.beats = 64;
        sb.push_back(e);
        @(negedge clk) b_init = 1'b1;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = b_mv;
        end
        check_eq("b_start", seen, 1);
        b_init = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (ps) void'(fifo_b.pop_front());
            if (pm) fifo_b.push_back(pm_val);
            if (b_done) break;
            b_mr = 1'($urandom_range(0, 1));
            b_sv = fifo_b.size() > 0;
            if (b_sv) {b_sl, b_sd} = fifo_b[0];
            else {b_sl, b_sd} = '0;
            pm = b_mv && b_mr;
            ps = b_sv && b_sr;
            if (pm) begin
                pm_val = {b_ml, b_md};
                if (first) check_eq("b_first", b_md, 64'h0000ACE1_0000ACE1);
                first = 0;
                if (qb.size() == 0) check_eq("b_extra_beat", 1, 0);
                else check_eq("b_beat", pm_val, qb.pop_front());
                kb++;
            end
            @(negedge clk);
        end
        b_mr = 1'b0;
        b_sv = 1'b0;
        b_sl = 1'b0;
        b_sd = '0;
        finish_run("b", b_done, b_err, b_cnt, 0, kb);
        check_eq("b_fifo_drained", fifo_b.size(), 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        a_init = 1'b0;
        b_init = 1'b0;
        b_mr   = 1'b0;
        b_sv   = 1'b0;
        b_sl   = 1'b0;
        b_sd   = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_a", {a_mv, a_ml, a_md, a_sr, a_done, a_err, a_cnt}, 0);
        check_eq("rst_b", {b_mv, b_ml, b_md, b_sr, b_done, b_err, b_cnt}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_a", {a_mv, a_sr}, 0);

        run_a(0, 0, 0, -1);
        run_a(1, 0, 0, -1);
        run_a(0, 0, 1, -1);
        run_b();
        run_a(0, 1, 0, -1);
        run_a(0, 0, 0, 30);
        run_a(0, 0, 0, -1);
        run_a(0, 0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_stream_loopback_checker.md
Name: axis_stream_loopback_checker

Overview:
Self-checking AXI-Stream traffic source and sink for closing a loop through an RX FIFO under test. A pulse on init_axi_txn launches NUM_FRAMES frames of NUM_BEATS beats on the master port. The block checks the returned stream on the slave port against an independently regenerated pattern and reports compare_done and a sticky error_out. It is a parametrised successor to the fixed single-width example top: configurable width, frame shape, pattern mode, sink backpressure and timeout.

Parameters:
DATA_WIDTH, 32, tdata width; multiple of 8, range 8..512.
NUM_BEATS, 16, beats per frame; range 1..65535.
NUM_FRAMES, 4, frames per run; range 1..65535.
PATTERN_MODE, 0, 0 = incrementing, 1 = LFSR.
READY_MASK, 8'hFF, per-cycle s_axis_tready enable mask, rotated LSB-first.
TIMEOUT, 1024, idle cycles on the slave port before an abort; 0 disables the timeout.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
init_axi_txn  in  1  start request, level; rising edge starts a run
m_axis_tdata  out  DATA_WIDTH  generated data
m_axis_tvalid  out  1  generated beat valid
m_axis_tlast  out  1  last beat of frame
m_axis_tready  in  1  downstream ready
s_axis_tdata  in  DATA_WIDTH  returned data
s_axis_tvalid  in  1  returned beat valid
s_axis_tlast  in  1  returned last
s_axis_tready  out  1  sink ready
compare_done  out  1  run finished, held until next start
error_out  out  1  sticky error flag
err_count  out  16  mismatch count, saturating at 16'hFFFF

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters and LFSRs at seed.
- Reset is asynchronous, may occur mid-run and aborts immediately. No tvalid glitch after release; the first valid appears only after a new start.
- Start detect: init_axi_txn is registered once; a start is reg & ~reg_d.
  - A start is honoured in IDLE and DONE only; it is ignored in RUN.
  - On start: clear error_out, err_count, compare_done; reseed both generators; enter RUN on the next cycle.
- FSM states: IDLE -> RUN on start; RUN -> DONE when the checker accepts the last beat of frame NUM_FRAMES-1, or on timeout; DONE -> RUN on start.
- Generator (master side):
  - m_axis_tvalid = 1 in RUN until the final beat is accepted.
  - Holds tdata, tlast and tvalid stable while tvalid & ~tready (AXIS rule).
  - Advances only on tvalid & tready.
  - tlast = (beat == NUM_BEATS-1).
- Pattern, incrementing mode: beat word = {frame[15:0], beat[15:0]}, zero-extended or truncated to DATA_WIDTH.
- Pattern, LFSR mode:
  - 32-bit Galois LFSR, taps 32'h80200003, seed 32'h0000ACE1.
  - Advances once per accepted beat.
  - The word is replicated to fill DATA_WIDTH, with the final copy truncated.
- Checker (slave side):
  - s_axis_tready = READY_MASK[phase] while in RUN, 0 otherwise.
  - phase is a 3-bit counter incrementing every RUN cycle, reset to 0 on start.
  - Beat accepted on s_axis_tvalid & s_axis_tready.
  - The checker carries its own frame/beat counters and its own LFSR, identical to the generator's but advanced only on accepted beats.
- Per accepted beat:
  - Mismatch if tdata != expected, or tlast != (expected beat == NUM_BEATS-1).
  - On mismatch: error_out <= 1 and err_count += 1 (saturating).
  - Counters still advance on mismatch, so there is no resync.
- Timeout: an idle counter counts RUN cycles with no accepted slave beat and clears on each accept. At TIMEOUT it sets error_out and moves the FSM to DONE; err_count does not increment.
- compare_done is asserted on entry to DONE and held there.
  - Latency: compare_done is high the cycle after the final beat is accepted.
  - The final beat's mismatch is reflected in error_out in that same cycle.
- Beats arriving in IDLE or DONE are not accepted (tready = 0).
- Simultaneous events: generator and checker advance independently in the same cycle. The timeout and final-beat accept are decided in the same cycle; the accept wins and the run is not flagged as a timeout.

Decomposition:
- Package axis_chk_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - LFSR_POLY and LFSR_SEED constants;
  - a function lfsr_next(logic [31:0]);
  - a function expand_word(pattern word -> DATA_WIDTH).
- One sub-module, axis_pattern_gen: counters plus LFSR, with an advance input and data/last outputs. It is instantiated twice, once for the generator and once for the checker, so both sides use identical pattern logic.

Test Plan:
- Direct loopback (m -> s wire), defaults, single start pulse -> 64 beats transferred; compare_done rises 1 cycle after the 64th accept; error_out = 0; err_count = 0.
- Same setup with bit 3 of beat 5, frame 2 flipped in the loop -> error_out = 1; err_count = 1; compare_done still asserts after 64 beats.
- PATTERN_MODE = 1, DATA_WIDTH = 64, READY_MASK = 8'b1010_0101, random m_axis_tready -> zero errors; the first beat is 64'h0000ACE1_0000ACE1.
- Loop broken after 10 beats, TIMEOUT = 32 -> error_out = 1 and compare_done = 1 exactly 32 cycles after the last accept; err_count = 0.
- aresetn pulled low mid-frame, then a new start -> all outputs 0 during reset; the rerun passes cleanly with err_count = 0.
- init_axi_txn held high through a run and re-pulsed during RUN -> no restart; the run completes once; a later pulse in DONE clears the flags and reruns.
